// File: rtl/fft8_pair_sequencer.sv
// fft8_pair_sequencer: collects eight samples into a register buffer in
// bit-reversed address order, steps an external radix-2 butterfly across the
// buffer for three in-place stages (4 pairs each), then streams the eight
// results out in natural order under valid/ready flow control.
module fft8_pair_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] bf_a,
  output logic [WIDTH-1:0] bf_b,
  output logic             bf_ctrl,
  input  logic [WIDTH-1:0] bf_c,
  input  logic [WIDTH-1:0] bf_d,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       n_q, n_d;     // arrival index of the next input sample
  logic [1:0]       s_q, s_d;     // butterfly stage
  logic [1:0]       k_q, k_d;     // pair index within the stage
  logic [2:0]       j_q, j_d;     // drain read index
  logic [WIDTH-1:0] mem_q [8];
  logic [2:0]       lo_addr, hi_addr;

  // Input sample n lands at address bitrev3(n) so the in-place stages
  // leave the results in natural order.
  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // Pair addresses: insert a zero at bit position s of k for the low
  // operand; the high operand is the same address with bit s set.
  always_comb begin
    lo_addr = 3'd0;
    case (s_q)
      2'd0:    lo_addr = {k_q, 1'b0};
      2'd1:    lo_addr = {k_q[1], 1'b0, k_q[0]};
      2'd2:    lo_addr = {1'b0, k_q};
      default: lo_addr = 3'd0;
    endcase
    hi_addr = lo_addr | (3'd1 << s_q);
  end

  // State and counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      n_q     <= 3'd0;
      s_q     <= 2'd0;
      k_q     <= 2'd0;
      j_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      s_q     <= s_d;
      k_q     <= k_d;
      j_q     <= j_d;
    end
  end

  // Next-state logic and all handshake / butterfly outputs.
  // NOTE: every output and next-state signal is given a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    s_d       = s_q;
    k_d       = k_q;
    j_d       = j_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    bf_a      = '0;
    bf_b      = '0;
    bf_ctrl   = 1'b0;   // add/subtract mode is the only one used
    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          n_d = n_q + 3'd1;
          if (n_q == 3'd7) begin
            state_d = ST_COMPUTE;
            s_d     = 2'd0;
            k_d     = 2'd0;
          end
        end
      end
      ST_COMPUTE: begin
        busy = 1'b1;
        bf_a = mem_q[lo_addr];
        bf_b = mem_q[hi_addr];
        k_d  = k_q + 2'd1;
        if (k_q == 2'd3) begin
          s_d = s_q + 2'd1;
          if (s_q == 2'd2) begin
            state_d = ST_DRAIN;
            s_d     = 2'd0;
            j_d     = 3'd0;
          end
        end
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem_q[j_q];
        out_last  = (j_q == 3'd7);
        if (out_ready) begin
          j_d = j_q + 3'd1;
          if (j_q == 3'd7) begin
            state_d = ST_LOAD;
            n_d     = 3'd0;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Sample buffer: written by accepted input beats in LOAD and by the
  // butterfly results in COMPUTE; untouched in DRAIN.
  // NOTE: the buffer is small and a reset must not leak a previous frame,
  // so it is cleared on reset like ordinary registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
    end else if (state_q == ST_LOAD && in_valid) begin
      mem_q[bitrev3(n_q)] <= in_data;
    end else if (state_q == ST_COMPUTE) begin
      mem_q[lo_addr] <= bf_c;
      mem_q[hi_addr] <= bf_d;
    end
  end

endmodule

// File: tb/tb_fft8_pair_sequencer.sv
// Bench for fft8_pair_sequencer: acts as the downstream butterfly, feeds
// frames, and compares drained results with a direct Walsh-Hadamard sum.
module tb_fft8_pair_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] bf_a, bf_b, bf_c, bf_d;
  logic         bf_ctrl;
  logic [W-1:0] out_data;
  logic         out_valid, out_last;
  logic         out_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] frame_x [8];
  logic [W-1:0] exp_y   [8];

  fft8_pair_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bf_a     (bf_a),
    .bf_b     (bf_b),
    .bf_ctrl  (bf_ctrl),
    .bf_c     (bf_c),
    .bf_d     (bf_d),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy)
  );

  // Downstream butterfly in add/subtract mode, wrapping at W bits.
  assign bf_c = bf_a + bf_b;
  assign bf_d = bf_a - bf_b;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output j = sum over n of x[n], negated when j & bitrev(n) has odd parity.
  function automatic void compute_expected();
    for (int j = 0; j < 8; j++) begin
      logic [W-1:0] acc;
      logic [2:0]   jb;
      acc = '0;
      jb  = 3'(j);
      for (int n = 0; n < 8; n++) begin
        logic [2:0] nb, nr;
        nb = 3'(n);
        nr = {nb[0], nb[1], nb[2]};
        if (($countones(jb & nr) % 2) == 1) acc = acc - frame_x[n];
        else                                acc = acc + frame_x[n];
      end
      exp_y[j] = acc;
    end
  endfunction

  // Offer frame_x[0..count-1]; leaves in_valid high after the last accept.
  task automatic feed_samples(input int count);
    for (int i = 0; i < count; i++) begin
      int budget;
      budget   = 0;
      in_valid = 1'b1;
      in_data  = frame_x[i];
      while (!in_ready && budget < 50) begin
        tick();
        budget++;
      end
      checks++;
      if (!in_ready) begin
        errors++;
        $display("FAIL feed_timeout sample %0d: in_ready=%b required 1", i, in_ready);
      end
      tick();
    end
  endtask

  // Feed one frame and drain it. mode 0: always ready, 1: toggle, 2: random.
  task automatic run_frame(input int mode, input bit hold_valid, input string tag);
    int lat;
    int cnt;
    int guard;
    bit prev_stall;
    logic [W-1:0] prev_data;
    compute_expected();
    out_ready = 1'b0;
    feed_samples(8);
    if (!hold_valid) in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || bf_ctrl !== 1'b0) begin
        errors++;
        $display("FAIL %s compute_flags cyc %0d: in_ready=%b busy=%b bf_ctrl=%b required 0 1 0",
                 tag, lat, in_ready, busy, bf_ctrl);
      end
      if (hold_valid) in_data = W'($urandom);
      tick();
      lat++;
    end
    checks++;
    if (lat != 13 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (out_valid=%b) required 13", tag, lat, out_valid);
    end
    cnt        = 0;
    guard      = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    while (cnt < 8 && guard < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s valid_drop at result %0d: out_valid=%b required 1", tag, cnt, out_valid);
        break;
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || bf_a !== '0 || bf_b !== '0) begin
        errors++;
        $display("FAIL %s drain_flags: in_ready=%b busy=%b bf_a=%h bf_b=%h required 0 1 0 0",
                 tag, in_ready, busy, bf_a, bf_b);
      end
      checks++;
      if (out_last !== (cnt == 7)) begin
        errors++;
        $display("FAIL %s out_last at result %0d: got %b required %b", tag, cnt, out_last, (cnt == 7));
      end
      if (prev_stall) begin
        checks++;
        if (out_data !== prev_data) begin
          errors++;
          $display("FAIL %s stall_hold: out_data=%h required %h", tag, out_data, prev_data);
        end
      end
      if (out_ready) begin
        checks++;
        if (out_data !== exp_y[cnt]) begin
          errors++;
          $display("FAIL %s result[%0d]: got %h required %h", tag, cnt, out_data, exp_y[cnt]);
        end
        cnt++;
      end
      prev_stall = !out_ready;
      prev_data  = out_data;
      if (hold_valid) in_data = W'($urandom);
      tick();
      guard++;
    end
    checks++;
    if (cnt != 8) begin
      errors++;
      $display("FAIL %s result_count: got %0d required 8", tag, cnt);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL %s return_to_load: in_ready=%b out_valid=%b busy=%b out_data=%h required 1 0 0 0",
               tag, in_ready, out_valid, busy, out_data);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
        out_data !== '0 || bf_a !== '0 || bf_b !== '0 || bf_ctrl !== 1'b0) begin
      errors++;
      $display("FAIL %s reset_outputs: in_ready=%b out_valid=%b out_last=%b busy=%b out_data=%h bf_a=%h bf_b=%h bf_ctrl=%b required 1 0 0 0 0 0 0 0",
               tag, in_ready, out_valid, out_last, busy, out_data, bf_a, bf_b, bf_ctrl);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs(tag);
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    check_reset_outputs("power_on");
    #10;
    rst_n = 1'b1;
    tick();
    check_reset_outputs("after_release");
  endtask

  task automatic test_vectors();
    for (int i = 0; i < 8; i++) frame_x[i] = 16'd1;
    run_frame(0, 1'b0, "all_ones");
    for (int i = 0; i < 8; i++) frame_x[i] = (i == 0) ? 16'd1 : 16'd0;
    run_frame(0, 1'b0, "impulse0");
    for (int i = 0; i < 8; i++) frame_x[i] = (i == 1) ? 16'd1 : 16'd0;
    run_frame(0, 1'b0, "impulse1");
    checks++;
    if (exp_y[3] !== 16'h0001 || exp_y[4] !== 16'hFFFF) begin
      errors++;
      $display("FAIL impulse1_model: y3=%h y4=%h required 0001 FFFF", exp_y[3], exp_y[4]);
    end
    for (int i = 0; i < 8; i++) frame_x[i] = 16'h7FFF;
    run_frame(0, 1'b0, "max_wrap");
    checks++;
    if (exp_y[0] !== 16'hFFF8) begin
      errors++;
      $display("FAIL max_wrap_model: y0=%h required FFF8", exp_y[0]);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) frame_x[i] = W'($urandom);
    run_frame(1, 1'b1, "toggle_ready");
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) frame_x[i] = W'($urandom);
      run_frame(2, 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) frame_x[i] = W'($urandom);
      run_frame(0, 1'b0, "back_to_back");
    end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 8; i++) frame_x[i] = W'($urandom);
    feed_samples(3);
    pulse_reset("mid_load");
    for (int i = 0; i < 8; i++) frame_x[i] = (i == 1) ? 16'd1 : 16'd0;
    run_frame(0, 1'b0, "after_load_reset");
  endtask

  task automatic test_reset_mid_compute();
    for (int i = 0; i < 8; i++) frame_x[i] = W'($urandom);
    feed_samples(8);
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();   // now in the 6th COMPUTE cycle
    pulse_reset("mid_compute");
    for (int i = 0; i < 8; i++) frame_x[i] = 16'd1;
    run_frame(0, 1'b0, "after_compute_reset");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid_load();
    test_reset_mid_compute();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
